// File: rtl/monobit_seq_ctrl_if.sv
// monobit_seq_ctrl_if: control, serial-bit and result signals of the monobit sequencer.
// master drives enable/start/abort/bits/threshold; slave returns status and results.
interface monobit_seq_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             ena;
    logic             start;
    logic             abort;
    logic             bit_valid;
    logic             bit_in;
    logic [CNT_W-1:0] thresh;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] ones_count;
    logic [CNT_W-1:0] sum_abs;
    logic [7:0]       blocks_done;
    logic             alarm;

    modport master (
        output ena, start, abort, bit_valid, bit_in, thresh,
        input  busy, done, pass, ones_count, sum_abs, blocks_done, alarm
    );

    modport slave (
        input  ena, start, abort, bit_valid, bit_in, thresh,
        output busy, done, pass, ones_count, sum_abs, blocks_done, alarm
    );
endinterface

// File: rtl/monobit_seq_ctrl.sv
// monobit_seq_ctrl: frames a serial bit stream into BLOCK_LEN-bit blocks, counts
// ones and grades |2*ones - BLOCK_LEN| against a threshold captured at start.
// Optional feature: define MONOBIT_FAIL_ALARM_EN for the consecutive-fail alarm.
module monobit_seq_ctrl #(
    parameter int unsigned BLOCK_LEN = 128,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    monobit_seq_ctrl_if.slave bus
);
    localparam int unsigned      SW       = CNT_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);
    localparam logic [SW-1:0]    BLEN_S   = SW'(BLOCK_LEN);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EVAL    = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] ones_q;
    logic [CNT_W-1:0] thresh_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [CNT_W-1:0] ones_count_q;
    logic [CNT_W-1:0] sum_abs_q;
    logic [7:0]       blocks_q;

    logic             accept_c;
    logic             take_bit_c;
    logic             commit_c;
    logic [SW-1:0]    s_c;
    logic [CNT_W-1:0] s_abs_c;
    logic             pass_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle strobes; everything holds while ena is low
    always_comb begin
        state_d    = state_q;
        accept_c   = 1'b0;
        take_bit_c = 1'b0;
        commit_c   = 1'b0;
        if (bus.ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        accept_c = 1'b1;
                        state_d  = ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (bus.abort) begin
                        state_d = ST_IDLE;
                    end else if (bus.bit_valid) begin
                        take_bit_c = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_EVAL;
                        end
                    end
                end
                ST_EVAL: begin
                    state_d  = ST_IDLE;
                    commit_c = !bus.abort;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Signed excess S = 2*ones - BLOCK_LEN (modular in SW bits) and its magnitude
    always_comb begin
        s_c     = {ones_q, 1'b0} - BLEN_S;
        s_abs_c = s_c[SW-1] ? CNT_W'(SW'(0) - s_c) : s_c[CNT_W-1:0];
        pass_c  = (s_abs_c <= thresh_q);
    end

    // Accumulator, threshold capture and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= '0;
            ones_q       <= '0;
            thresh_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            ones_count_q <= '0;
            sum_abs_q    <= '0;
            blocks_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.ena) begin
                busy_q <= (state_d != ST_IDLE);
                if (accept_c) begin
                    thresh_q <= bus.thresh;
                    idx_q    <= '0;
                    ones_q   <= '0;
                end
                if (take_bit_c) begin
                    idx_q  <= idx_q + CNT_W'(1);
                    ones_q <= ones_q + CNT_W'(bus.bit_in);
                end
                if (commit_c) begin
                    ones_count_q <= ones_q;
                    sum_abs_q    <= s_abs_c;
                    pass_q       <= pass_c;
                    done_q       <= 1'b1;
                    blocks_q     <= blocks_q + 8'd1;
                end
            end
        end
    end

`ifdef MONOBIT_FAIL_ALARM_EN
    logic [1:0] fail_cnt_q;
    logic       alarm_q;

    // Saturating consecutive-fail counter; a passing block clears it and the alarm
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_cnt_q <= 2'd0;
            alarm_q    <= 1'b0;
        end else if (commit_c) begin
            if (pass_c) begin
                fail_cnt_q <= 2'd0;
                alarm_q    <= 1'b0;
            end else begin
                if (fail_cnt_q != 2'd3) begin
                    fail_cnt_q <= fail_cnt_q + 2'd1;
                end
                if (fail_cnt_q >= 2'd2) begin
                    alarm_q <= 1'b1;
                end
            end
        end
    end

    assign bus.alarm = alarm_q;
`else
    assign bus.alarm = 1'b0;
`endif

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.ones_count  = ones_count_q;
    assign bus.sum_abs     = sum_abs_q;
    assign bus.blocks_done = blocks_q;
endmodule
